intr_ctrl: RTL and testbench
============================

# intr_ctrl

Parametrised interrupt controller that replaces the single `irr` request line seen by the CPU core. It collects `NUM_SRC` interrupt sources, latches or tracks them per source mode, applies a per-source mask and the CPU's global `intr_en`, and arbitrates by fixed priority. It presents one request with its vector and source id to the CPU execute stage, then holds off further requests until the handler signals end-of-interrupt.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, 1..16.
- `EDGE_MASK`, `{NUM_SRC{1'b1}}`: per-source mode; 1 = rising-edge latched, 0 = level.
- `VEC_BASE`, 32'h0000_0100: vector of source 0.
- `VEC_STRIDE`, 32'h0000_0010: vector spacing between sources.

Ports. One clock; reset is synchronous and active-high.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `irq`, in, NUM_SRC: raw source lines, already synchronous to `clk`.
- `intr_en`, in, 1: global enable, driven from the special-register `intr_en`.
- `mask_we`, in, 1: write strobe for the mask register.
- `mask_wdata`, in, NUM_SRC: new mask; bit 1 enables that source.
- `ack`, in, 1: CPU accepted the current request.
- `eoi`, in, 1: handler finished, issued on interrupt return.
- `irr`, out, 1: interrupt request to the CPU.
- `intr_vec`, out, 32: handler address of the granted source.
- `intr_id`, out, $clog2(NUM_SRC) (min 1): granted source index.
- `pending`, out, NUM_SRC: pending register, for debug/status.
- `mask`, out, NUM_SRC: current mask.

## Operation
- Edge sources:
  - `irq_q` holds the previous cycle's `irq`.
  - A rising edge is `irq & ~irq_q`; it sets the pending bit at the next clock.
  - The pending bit clears on `ack` when that source is `intr_id`.
  - If an edge and a clearing `ack` hit the same bit in the same cycle, the set wins.
- Level sources: the pending bit equals `irq` registered each cycle and is never cleared by `ack`.
- Eligible sources: `pending & mask`. The grant goes to the lowest index, which has the highest priority.
- State machine with states IDLE, REQ, SERVICE:
  - IDLE → REQ when `intr_en` and eligible is non-zero. Latch `intr_id` and `intr_vec = VEC_BASE + intr_id*VEC_STRIDE`, and set `irr`.
  - REQ → SERVICE on `ack`. Clear `irr`.
  - REQ → IDLE if `intr_en` drops or the latched source is no longer eligible before `ack` (mask written, or level line falls). Clear `irr`; the CPU never sees a stale vector.
  - SERVICE → IDLE on `eoi`. There is no nesting; sources arriving in SERVICE stay pending.
  - `ack` outside REQ and `eoi` outside SERVICE are ignored.
- `intr_id`/`intr_vec` are held constant throughout REQ and SERVICE.
- Vector arithmetic is 32-bit unsigned and wraps modulo 2^32.
- A mask write takes effect at the next clock. Masking a source does not clear its pending bit.

## Timing
- Reset values: state IDLE; `irr`=0, `intr_vec`=0, `intr_id`=0, `pending`=0, `irq_q`=0, `mask`=all 1s.
- Reset asserted mid-REQ or mid-SERVICE returns everything to reset values at that clock edge; the pending bits are lost.
- Edge latency, with IDLE and enabled: `irq` rises in cycle t → `pending` set in t+1 → `irr`=1 in t+2.
- Level latency: the same, 2 cycles.
- `ack` sampled in cycle a → `irr`=0 in a+1 → edge pending bit cleared in a+1.
- `eoi` in cycle e → IDLE in e+1. A still-eligible source re-raises `irr` in e+2, so there is a minimum of 1 idle cycle between requests.
- `ack` and `eoi` together in REQ: `ack` is taken and `eoi` is ignored.

## Structure
- Add to the shared CPU package:
  - `INTR_STATE` enum (IDLE/REQ/SERVICE).
  - Packed struct `INTR_REQ` {`irr`, `intr_id`, `intr_vec`}, so the DECODE/EXECUTE structs can carry it.
- One sub-module, `prio_enc`: parametrised fixed-priority encoder (NUM_SRC → index + valid), combinational.

## Test plan
1. Reset, NUM_SRC=4, all edge. Pulse `irq[2]` one cycle at t → `irr`=1 at t+2, `intr_id`=2, `intr_vec`=0x120. `ack` → `pending[2]`=0. `eoi` → IDLE, `irr` stays 0.
2. `irq[3]` and `irq[1]` rise the same cycle → grant id 1 (vector 0x110). After `ack`+`eoi`, id 3 is requested 2 cycles after `eoi`.
3. Source 0 level mode held high: `ack` leaves `pending[0]`=1. After `eoi`, `irr` re-asserts at e+2. Drop `irq[0]` while in REQ → `irr`=0 next cycle, back to IDLE.
4. `mask`=4'b1110 with `irq[0]` edge → `pending[0]`=1, `irr`=0. Write `mask`=4'b1111 → `irr`=1 two cycles after the write.
5. `intr_en`=0 with sources pending → `irr` stays 0. Raise `intr_en` → `irr` next cycle. Drop `intr_en` in REQ → `irr`=0, pending retained.
6. `rst` asserted during SERVICE with `pending`=4'b0101 → next cycle all outputs are at reset values. A new edge on `irq[3]`, with `irq_q` cleared at reset, → request id 3.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared types for the interrupt controller
// Purpose: FSM state enum, request struct carried by DECODE/EXECUTE, id width helper.
package intr_ctrl_pkg;

  localparam int MAX_SRC  = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } INTR_STATE;

  // Sized for the largest source count so pipeline structs need no parameter.
  typedef struct packed {
    logic                irr;
    logic [MAX_ID_W-1:0] intr_id;
    logic [31:0]         intr_vec;
  } INTR_REQ;

  // Source index width, never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - CPU-side request/acknowledge interface
// Purpose: bundles the CPU handshake.
// Ports: intr_en/ack/eoi from the CPU (master); irr/intr_vec/intr_id from the controller (slave).
interface intr_ctrl_if
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
);
  localparam int ID_W = id_width(NUM_SRC);

  logic            intr_en;
  logic            ack;
  logic            eoi;
  logic            irr;
  logic [31:0]     intr_vec;
  logic [ID_W-1:0] intr_id;

  modport master (output intr_en, ack, eoi, input irr, intr_vec, intr_id);
  modport slave  (input intr_en, ack, eoi, output irr, intr_vec, intr_id);
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// rtl/intr_ctrl_prio_enc.sv - fixed-priority encoder, lowest index wins
// Ports: req (N request bits) in; idx (W-bit index of lowest set bit), valid (any set) out.
module prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan downward so the last hit, the lowest index, is what remains.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: pending capture, mask, priority, request FSM
// Ports: clk, rst (sync active-high); irq source lines; mask_we/mask_wdata mask write;
//        pending, mask status out; bus (slave) carries intr_en/ack/eoi in, irr/intr_vec/intr_id out.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC    = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK  = {NUM_SRC{1'b1}},
  parameter logic [31:0]        VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0]        VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  intr_ctrl_if.slave         bus
);

  localparam int ID_W = id_width(NUM_SRC);

  INTR_STATE          state;
  INTR_REQ            req_q;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] id_onehot;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic [31:0]        grant_vec;
  logic               ack_taken;
  logic               still_eligible;

  assign ack_taken = (state == REQ) && bus.ack;
  assign id_onehot = NUM_SRC'(1) << req_q.intr_id;
  assign rise      = irq & ~irq_q;
  assign ack_clr   = ack_taken ? id_onehot : '0;

  // Edge bits: a new edge beats a same-cycle clearing ack. Level bits follow irq.
  assign pending_nxt = (EDGE_MASK & (rise | (pending & ~ack_clr))) | (~EDGE_MASK & irq);
  assign eligible    = pending & mask;

  // Looking at next-cycle pending lets a falling level line withdraw irr one cycle later.
  assign still_eligible = |(pending_nxt & mask & id_onehot);

  prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .idx   (grant_id),
    .valid (grant_valid)
  );

  assign grant_vec = VEC_BASE + 32'(grant_id) * VEC_STRIDE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      pending <= '0;
      irq_q   <= '0;
      mask    <= '1;
    end else begin
      irq_q   <= irq;
      pending <= pending_nxt;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      case (state)
        IDLE: begin
          if (bus.intr_en && grant_valid) begin
            state          <= REQ;
            req_q.irr      <= 1'b1;
            req_q.intr_id  <= MAX_ID_W'(grant_id);
            req_q.intr_vec <= grant_vec;
          end
        end
        REQ: begin
          // ack wins over a same-cycle withdrawal: the vector shown was valid.
          if (ack_taken) begin
            state     <= SERVICE;
            req_q.irr <= 1'b0;
          end else if (!bus.intr_en || !still_eligible) begin
            state     <= IDLE;
            req_q.irr <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irr      = req_q.irr;
  assign bus.intr_vec = req_q.intr_vec;
  assign bus.intr_id  = req_q.intr_id[ID_W-1:0];

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl (source 0 level, sources 1..3 edge)
module tb_intr_ctrl;

  typedef struct {
    int          id;
    logic [31:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] pending;
  logic [3:0] mask;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic irr_prev = 1'b0;

  intr_ctrl_if #(.NUM_SRC(4)) bus ();

  intr_ctrl #(
    .NUM_SRC    (4),
    .EDGE_MASK  (4'b1110),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pending    (pending),
    .mask       (mask),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input int id, input logic [31:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    sb_q.push_back(e);
  endtask

  // Monitor: every new request presented by the DUT is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.irr && !irr_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_req", {30'd0, bus.intr_id}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("req_id", {30'd0, bus.intr_id}, e.id);
        chk("req_vec", bus.intr_vec, e.vec);
      end
    end
    irr_prev = rst ? 1'b0 : bus.irr;
  end

  initial begin
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
    bus.intr_en = 1'b1; bus.ack = 1'b0; bus.eoi = 1'b0;
    tick(); tick();
    chk("rst_irr", bus.irr, 0);
    chk("rst_id", bus.intr_id, 0);
    chk("rst_vec", bus.intr_vec, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mask", mask, 4'hF);
    rst = 1'b0;
    tick();

    // 1: single edge on source 2
    irq = 4'b0100; expect_req(2, 32'h120);
    tick(); irq = '0;
    chk("t1_pending", pending, 4'b0100);
    chk("t1_irr_t1", bus.irr, 0);
    tick();
    chk("t1_irr_t2", bus.irr, 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t1_irr_ack", bus.irr, 0);
    chk("t1_pend_ack", pending, 0);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0; tick();
    chk("t1_idle_irr", bus.irr, 0);

    // 2: simultaneous edges on 3 and 1, lower index first
    irq = 4'b1010; expect_req(1, 32'h110); expect_req(3, 32'h130);
    tick(); irq = '0; tick();
    chk("t2_irr", bus.irr, 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t2_pend_ack", pending, 4'b1000);
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
    chk("t2_irr_e1", bus.irr, 0);
    tick();
    chk("t2_irr_e2", bus.irr, 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0; tick();
    chk("t2_done_irr", bus.irr, 0);
    chk("t2_done_pend", pending, 0);

    // 3: level source 0
    irq = 4'b0001; expect_req(0, 32'h100);
    tick();
    chk("t3_pending", pending, 4'b0001);
    tick();
    chk("t3_irr", bus.irr, 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("t3_pend_ack", pending, 4'b0001);
    chk("t3_irr_ack", bus.irr, 0);
    bus.eoi = 1'b1; expect_req(0, 32'h100); tick(); bus.eoi = 1'b0;
    chk("t3_irr_e1", bus.irr, 0);
    tick();
    chk("t3_irr_e2", bus.irr, 1);
    irq = '0; tick();
    chk("t3_drop_irr", bus.irr, 0);
    tick();
    chk("t3_drop_pend", pending, 0);
    chk("t3_drop_irr2", bus.irr, 0);

    // 4: masked edge source stays pending, unmask raises irr two cycles after the write
    mask_we = 1'b1; mask_wdata = 4'b1101; tick(); mask_we = 1'b0;
    chk("t4_mask", mask, 4'b1101);
    irq = 4'b0010; tick(); irq = '0;
    chk("t4_pending", pending, 4'b0010);
    tick(); tick();
    chk("t4_masked_irr", bus.irr, 0);
    mask_we = 1'b1; mask_wdata = 4'b1111; expect_req(1, 32'h110);
    tick(); mask_we = 1'b0;
    chk("t4_irr_w1", bus.irr, 0);
    tick();
    chk("t4_irr_w2", bus.irr, 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0; tick();

    // 5: global enable gating, withdrawal, then ack+eoi together
    bus.intr_en = 1'b0;
    irq = 4'b0100; tick(); irq = '0; tick(); tick();
    chk("t5_dis_irr", bus.irr, 0);
    chk("t5_dis_pend", pending, 4'b0100);
    bus.intr_en = 1'b1; expect_req(2, 32'h120); tick();
    chk("t5_en_irr", bus.irr, 1);
    bus.intr_en = 1'b0; tick();
    chk("t5_drop_irr", bus.irr, 0);
    chk("t5_drop_pend", pending, 4'b0100);
    bus.intr_en = 1'b1; expect_req(2, 32'h120); tick();
    chk("t5_reen_irr", bus.irr, 1);
    bus.ack = 1'b1; bus.eoi = 1'b1; tick(); bus.ack = 1'b0; bus.eoi = 1'b0;
    chk("t5_ackeoi_irr", bus.irr, 0);
    chk("t5_ackeoi_pend", pending, 0);

    // 6: stays in SERVICE (eoi ignored) with pending 0101, then reset clears all
    irq = 4'b0101; tick(); irq = 4'b0001; tick(); tick();
    chk("t6_svc_irr", bus.irr, 0);
    chk("t6_svc_pend", pending, 4'b0101);
    rst = 1'b1; irq = '0; tick(); rst = 1'b0;
    chk("t6_rst_irr", bus.irr, 0);
    chk("t6_rst_id", bus.intr_id, 0);
    chk("t6_rst_vec", bus.intr_vec, 0);
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_mask", mask, 4'hF);
    irq = 4'b1000; expect_req(3, 32'h130);
    tick(); irq = '0; tick();
    chk("t6_irr", bus.irr, 1);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    bus.eoi = 1'b1; tick(); bus.eoi = 1'b0; tick(); tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
